apa102_tx: RTL

// - Serializer that drives an APA102 LED string from the 512x24 LED data buffer of the

---
 rtl/apa102_tx_pkg.sv | 23 ++
 rtl/apa102_bit_timer.sv | 38 +++
 rtl/apa102_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/apa102_tx_pkg.sv
// Shared definitions for the APA102 string serializer: FSM encodings, frame
// constants and the end-frame length helper.
package apa102_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FETCH = 3'd2,
    ST_LED   = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam int START_BITS = 32;
  localparam int LED_BITS   = 32;
  localparam int END_BASE   = 32;
  localparam logic [2:0] LED_HDR = 3'b111;

  // End frame needs half a clock per LED to push data through the string.
  function automatic logic [9:0] end_bit_count(input logic [9:0] n);
    return 10'(END_BASE) + (((n + 10'd15) >> 4) << 3);
  endfunction

endpackage

// File: rtl/apa102_bit_timer.sv
// SCK generator for the APA102 serializer: a reloading down-counter toggles
// led_clk every div+1 cycles and flags the last cycle of each phase.
module apa102_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             fall_tick,
  output logic             rise_tick,
  output logic             led_clk
);

  logic [DIV_W-1:0] cnt_q;
  logic             phase_q;
  logic             tc;

  assign tc = (cnt_q == '0);

  // Held at reload value while disabled so every bit starts with a full low phase.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q   <= div;
      phase_q <= 1'b0;
    end else if (tc) begin
      cnt_q   <= div;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rise_tick = en && !phase_q && tc;
  assign fall_tick = en && phase_q && tc;
  assign led_clk   = phase_q;

endmodule

// File: rtl/apa102_tx.sv
// APA102 serializer: streams a start frame, one frame per buffered LED and an
// end frame, fetching each LED word from the buffer just before its frame.
module apa102_tx
  import apa102_tx_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [4:0]        glob,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       rd_data,
  output logic              busy,
  output logic              led_clk,
  output logic              led_data
);

  // state | meaning
  // IDLE  | waiting for start, led_clk low
  // START | 32 zero bits
  // FETCH | read LED word (rd_en cycle, then data cycle)
  // LED   | 32-bit LED frame
  // END   | trailing one bits

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, idx_q, idx_inc;
  logic [4:0]        glob_q;
  logic [DIV_W-1:0]  div_q, div_sel;
  logic [31:0]       shift_q;
  logic [9:0]        bit_cnt_q;
  logic              fetch_wait_q;
  logic              timer_en, fall_tick, rise_tick, frame_done;

  // The timer preloads while idle, so feed it the divider being latched.
  assign div_sel = (state_q == ST_IDLE) ? div : div_q;

  apa102_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (timer_en),
    .div       (div_sel),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick),
    .led_clk   (led_clk)
  );

  assign idx_inc    = idx_q + ADDR_W'(1);
  assign frame_done = fall_tick && (bit_cnt_q == 10'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    timer_en = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_START;
      ST_START: begin
        timer_en = 1'b1;
        if (frame_done) state_d = (len_q != '0) ? ST_FETCH : ST_END;
      end
      ST_FETCH: begin
        rd_en = !fetch_wait_q;
        if (fetch_wait_q) state_d = ST_LED;
      end
      ST_LED: begin
        timer_en = 1'b1;
        if (frame_done) state_d = (idx_inc < len_q) ? ST_FETCH : ST_END;
      end
      ST_END: begin
        timer_en = 1'b1;
        if (frame_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bit_cnt counts bits still to be sampled; it hits zero on the last rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      glob_q       <= '0;
      div_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      fetch_wait_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q     <= len;
            glob_q    <= glob;
            div_q     <= div;
            idx_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= 10'(START_BITS);
          end
        end
        ST_FETCH: begin
          fetch_wait_q <= ~fetch_wait_q;
          if (fetch_wait_q) begin
            shift_q   <= {LED_HDR, glob_q, rd_data};
            bit_cnt_q <= 10'(LED_BITS);
          end
        end
        default: begin
          if (rise_tick) bit_cnt_q <= bit_cnt_q - 10'd1;
          if (fall_tick) begin
            if (!frame_done) begin
              shift_q <= {shift_q[30:0], state_q == ST_END};
            end else begin
              if (state_q == ST_LED) idx_q <= idx_inc;
              if (state_d == ST_END) begin
                shift_q   <= '1;
                bit_cnt_q <= end_bit_count(10'(len_q));
              end else if (state_d == ST_IDLE) begin
                shift_q <= '0;
                idx_q   <= '0;
              end
            end
          end
        end
      endcase
    end
  end

  assign rd_addr  = idx_q;
  assign busy     = (state_q != ST_IDLE);
  assign led_data = shift_q[31];

endmodule
